fault_test_sequencer: RTL and testbench
=======================================

// Module: fault_test_sequencer
// PURPOSE
//  Test controller for the 4-input single-output gate-level circuit under test (CUT).
//  - Applies all 16 input vectors in ascending order.
//  - Waits a settle interval per vector, then samples the CUT output.
//  - Compares the sample against a built-in golden model; counts mismatches and records the first failing vector.
//  - Used to detect injected stuck-at faults (e.g. output stuck-at-0/1) without hand-written vector benches.
// PARAMETERS
//  SETTLE_CYC  2   cycles cut_vec is held before cut_resp is sampled (legal >=1)
// PORTS
//  clk               in   1  rising-edge clock, single clock domain
//  rst               in   1  reset, asynchronous, active-high
//  start             in   1  begin a run; sampled only in IDLE
//  abort             in   1  cancel a run in progress; returns to IDLE
//  stop_on_fail      in   1  1 = end run at first mismatch; sampled with start
//  cut_resp          in   1  CUT output, driven from cut_vec
//  cut_vec           out  4  CUT inputs: [3]=one [2]=two [1]=three [0]=four
//  busy              out  1  1 while a run is in progress (WAIT/CHECK)
//  done              out  1  one-cycle pulse when a run completes (not on abort)
//  pass              out  1  1 = last completed run had zero mismatches; held until next start
//  fail_count        out  5  number of mismatching vectors in the current/last run (0..16)
//  first_fail_valid  out  1  1 once a mismatch has been recorded in this run
//  first_fail_vec    out  4  cut_vec value of the first mismatch
// BEHAVIOUR
//  - Golden model: exp = (v[2]|v[1]|v[0]) & ~(v[3]&v[2]), with v = cut_vec.
//    - Expected response is 1 for 10 vectors and 0 for vectors 0, 8, 12, 13, 14, 15.
//  - Reset: state=IDLE; cut_vec=0; busy/done/pass=0; fail_count=0; first_fail_valid=0; first_fail_vec=0.
//  - States: IDLE, WAIT, CHECK, DONE. All outputs are registered.
//  - IDLE:
//    - start=1 and abort=0 -> cut_vec<=0, settle_cnt<=SETTLE_CYC, clear fail_count/first_fail_*/pass.
//    - Latch stop_on_fail, go to WAIT.
//  - WAIT: settle_cnt decrements each cycle; when settle_cnt==1 go to CHECK. WAIT lasts exactly SETTLE_CYC cycles.
//  - CHECK (1 cycle): mismatch = cut_resp != exp(cut_vec).
//    - On mismatch: fail_count+1; if first_fail_valid==0, set first_fail_vec=cut_vec and first_fail_valid=1.
//    - End run if cut_vec==15, or if (latched stop_on_fail && mismatch): go to DONE.
//    - Otherwise cut_vec<=cut_vec+1, reload settle_cnt, go to WAIT.
//  - DONE (1 cycle): done=1; pass<=(fail_count==0) using the final count; next state IDLE. cut_vec holds its last value.
//  - Latency: each vector costs SETTLE_CYC+1 cycles.
//    - Full run: done is high in cycle 16*(SETTLE_CYC+1)+1 after the start-sampling edge.
//    - With SETTLE_CYC=2, done is high in cycle 49.
//  - start outside IDLE is ignored; no queueing.
//  - abort in WAIT/CHECK:
//    - Go to IDLE next edge; busy=0; no done pulse; pass stays 0.
//    - fail_count/first_fail_* keep their partial values.
//    - An abort in CHECK takes priority over that cycle's compare update.
//  - start and abort together in IDLE: abort wins; stay IDLE.
//  - abort in DONE: ignored; done still pulses.
//  - rst asserted mid-run: immediate return to reset values; no done pulse.
//  - fail_count is 5 bits so 16 mismatches is representable; no wrap and no saturation needed.
// TESTING
//  - Fault-free CUT (gate model), SETTLE_CYC=2, start ->
//    - busy for 48 cycles, then done pulse; pass=1, fail_count=0, first_fail_valid=0.
//  - CUT output stuck-at-1, stop_on_fail=0 ->
//    - fail_count=6, first_fail_vec=0, first_fail_valid=1, pass=0.
//  - CUT output stuck-at-0, stop_on_fail=1 ->
//    - done after vector 1 (cycle 7), fail_count=1, first_fail_vec=1, cut_vec=1.
//  - Fault-free run; abort in WAIT of vector 5 ->
//    - IDLE next cycle, no done, busy=0, pass=0; a new start then completes with pass=1.
//  - start pulsed again mid-run; start+abort together in IDLE; rst asserted in CHECK of vector 9 ->
//    - re-start is ignored (run completes normally);
//    - start+abort leaves the block in IDLE;
//    - rst returns every output to its reset value immediately.

Source files
------------

// File: rtl/fault_test_sequencer.sv
// Exhaustive 16-vector test controller for a 4-input, 1-output CUT.
// Ports: clk/rst, start/abort/stop_on_fail in, cut_vec/cut_resp to CUT, status out.
module fault_test_sequencer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       stop_on_fail,
  input  logic       cut_resp,
  output logic [3:0] cut_vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_vec
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] settle_cnt;
  logic          stop_lat;

  logic          exp_resp;
  logic          mismatch;
  logic [4:0]    cnt_next;
  logic          end_run;

  // Golden model of the fault-free circuit
  always_comb begin
    exp_resp = (cut_vec[2] | cut_vec[1] | cut_vec[0])
             & ~(cut_vec[3] & cut_vec[2]);
    mismatch = cut_resp ^ exp_resp;
    cnt_next = fail_count + {4'd0, mismatch};
    end_run  = (cut_vec == 4'hf) || (stop_lat && mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      stop_lat         <= 1'b0;
      cut_vec          <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= 5'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            cut_vec          <= 4'd0;
            settle_cnt       <= CW'(SETTLE_CYC);
            fail_count       <= 5'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 4'd0;
            pass             <= 1'b0;
            stop_lat         <= stop_on_fail;
            busy             <= 1'b1;
            state            <= WAIT;
          end
        end
        WAIT: begin
          settle_cnt <= settle_cnt - CW'(1);
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (settle_cnt == CW'(1)) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          // abort wins over this cycle's compare update
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            fail_count <= cnt_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= cut_vec;
            end
            if (end_run) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              // final count includes this vector's result
              pass  <= (cnt_next == 5'd0);
              state <= DONE;
            end else begin
              cut_vec    <= cut_vec + 4'd1;
              settle_cnt <= CW'(SETTLE_CYC);
              state      <= WAIT;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_test_sequencer.sv
// Self-checking bench: vector table, directed corner cases, random faults.
// Reference model computes results from the golden truth table directly.
module tb_fault_test_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       stop_on_fail;
  logic       cut_resp;
  logic [3:0] cut_vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_count;
  logic       first_fail_valid;
  logic [3:0] first_fail_vec;

  // CUT selection: 0 gate model, 1 stuck-at-0, 2 stuck-at-1, 3 truth table
  logic [1:0]  mode;
  logic [15:0] tt;
  logic        one, two, three, four, gate_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign one   = cut_vec[3];
  assign two   = cut_vec[2];
  assign three = cut_vec[1];
  assign four  = cut_vec[0];
  assign gate_out = (two | three | four) & ~(one & two);

  always_comb begin
    cut_resp = gate_out;
    case (mode)
      2'd1: cut_resp = 1'b0;
      2'd2: cut_resp = 1'b1;
      2'd3: cut_resp = tt[cut_vec];
      default: cut_resp = gate_out;
    endcase
  end

  fault_test_sequencer #(.SETTLE_CYC(S)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .stop_on_fail(stop_on_fail),
    .cut_resp(cut_resp),
    .cut_vec(cut_vec),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_count(fail_count),
    .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected response: 1 everywhere except vectors 0, 8, 12..15
  function automatic logic [15:0] golden_tt();
    logic [15:0] g;
    int zeros[6] = '{0, 8, 12, 13, 14, 15};
    g = 16'hffff;
    foreach (zeros[i]) g[zeros[i]] = 1'b0;
    return g;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    stop_on_fail = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Start a run; return the cycle (1 = after the start edge) done rose in
  task automatic run(input logic [1:0] m, input logic [15:0] t,
                     input logic sof, output int dcyc, output int busyc);
    mode = m;
    tt = t;
    stop_on_fail = sof;
    start = 1'b1;
    step();
    start = 1'b0;
    stop_on_fail = 1'b0;
    dcyc = -1;
    busyc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) busyc++;
      if (done) begin
        dcyc = c;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] m;
    logic       sof;
    int         cnt;
    int         ffv;
    int         ffvec;
    int         dcyc;
    int         lastvec;
    int         pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int dc, bc;
    logic [15:0] t, g;
    logic sof;
    int ecnt, effv, effvec, last;

    mode = 2'd0;
    tt = 16'd0;
    do_reset();

    chk("rst_cut_vec", cut_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_ffv", first_fail_valid, 0);
    chk("rst_ffvec", first_fail_vec, 0);

    tbl[0] = '{"good",     2'd0, 1'b0, 0,  0, 0, 49, 15, 1};
    tbl[1] = '{"sa1",      2'd2, 1'b0, 6,  1, 0, 49, 15, 0};
    tbl[2] = '{"sa1_stop", 2'd2, 1'b1, 1,  1, 0, 4,  0,  0};
    tbl[3] = '{"sa0",      2'd1, 1'b0, 10, 1, 1, 49, 15, 0};
    tbl[4] = '{"sa0_stop", 2'd1, 1'b1, 1,  1, 1, 7,  1,  0};

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].m, 16'd0, tbl[i].sof, dc, bc);
      chk({tbl[i].name, "_done_cyc"}, dc, tbl[i].dcyc);
      chk({tbl[i].name, "_busy_cyc"}, bc, tbl[i].dcyc - 1);
      chk({tbl[i].name, "_busy_at_done"}, busy, 0);
      chk({tbl[i].name, "_cnt"}, fail_count, tbl[i].cnt);
      chk({tbl[i].name, "_ffv"}, first_fail_valid, tbl[i].ffv);
      chk({tbl[i].name, "_ffvec"}, first_fail_vec, tbl[i].ffvec);
      chk({tbl[i].name, "_cut_vec"}, cut_vec, tbl[i].lastvec);
      step();
      chk({tbl[i].name, "_done_pulse"}, done, 0);
      chk({tbl[i].name, "_pass"}, pass, tbl[i].pass);
      step();
    end

    // Abort in WAIT of vector 5 (cycles 16,17), then a clean rerun
    mode = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 16; c++) step();
    chk("abort_vec", cut_vec, 5);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass, 0);
    dc = 0;
    for (int c = 0; c < 60; c++) begin
      if (done || busy) dc++;
      step();
    end
    chk("abort_no_done", dc, 0);
    run(2'd0, 16'd0, 1'b0, dc, bc);
    chk("rerun_done_cyc", dc, 49);
    step();
    chk("rerun_pass", pass, 1);

    // Abort in CHECK of vector 0 with stuck-at-1: compare discarded
    mode = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_chk_cnt", fail_count, 0);
    chk("abort_chk_ffv", first_fail_valid, 0);
    chk("abort_chk_busy", busy, 0);
    step();

    // Second start mid-run is ignored
    mode = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    dc = -1;
    for (int c = 11; c <= 200; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      step();
    end
    chk("restart_done_cyc", dc, 49);
    chk("restart_cut_vec", cut_vec, 15);
    step();
    chk("restart_pass", pass, 1);

    // start + abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    step();
    chk("start_abort_busy2", busy, 0);
    chk("start_abort_pass_held", pass, 1);

    // rst asserted in CHECK of vector 9 (cycle 30), stuck-at-1
    mode = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 30; c++) step();
    chk("rst_mid_vec", cut_vec, 9);
    chk("rst_mid_cnt_before", fail_count, 2);
    rst = 1'b1;
    #1;
    chk("rst_mid_cut_vec", cut_vec, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_cnt", fail_count, 0);
    chk("rst_mid_ffv", first_fail_valid, 0);
    chk("rst_mid_ffvec", first_fail_vec, 0);
    step();
    rst = 1'b0;
    dc = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) dc++;
      step();
    end
    chk("rst_mid_quiet", dc, 0);

    // Random truth-table faults against the reference model
    g = golden_tt();
    for (int it = 0; it < 24; it++) begin
      t = g;
      if ($urandom_range(3) != 0) t = g ^ 16'($urandom);
      sof = 1'($urandom);
      ecnt = 0;
      effv = 0;
      effvec = 0;
      last = 15;
      for (int v = 0; v < 16; v++) begin
        if (t[v] != g[v]) begin
          ecnt++;
          if (effv == 0) begin
            effv = 1;
            effvec = v;
          end
          if (sof) begin
            last = v;
            break;
          end
        end
      end
      run(2'd3, t, sof, dc, bc);
      chk("rnd_done_cyc", dc, (last + 1) * (S + 1) + 1);
      chk("rnd_cnt", fail_count, ecnt);
      chk("rnd_ffv", first_fail_valid, effv);
      if (effv != 0) chk("rnd_ffvec", first_fail_vec, effvec);
      chk("rnd_cut_vec", cut_vec, last);
      step();
      chk("rnd_pass", pass, (ecnt == 0) ? 1 : 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
